// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch controller: conditions three raw buttons, sequences the time counter
// through IDLE/RUNNING/STOPPED and keeps a small bank of captured lap times.
//
// state   | meaning
// IDLE    | counter stopped and cleared, waiting for start
// RUNNING | counter enabled, laps may be captured
// STOPPED | counter held, display can be unfrozen, clear returns to IDLE
module stopwatch_ctrl_fsm #(
    parameter int TIME_W          = 24,
    parameter int LAP_DEPTH       = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LAP_IDX_W       = 3
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start_stop,
    input  logic                 lap_time,
    input  logic                 clear,
    input  logic [TIME_W-1:0]    time_in,
    input  logic [LAP_IDX_W-1:0] lap_sel,
    output logic                 counter_enable,
    output logic                 counter_clear,
    output logic                 display_enable,
    output logic [TIME_W-1:0]    lap_data,
    output logic [LAP_IDX_W-1:0] lap_count,
    output logic                 lap_overflow,
    output logic [1:0]           state_out
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STOP = 2'b10;

    localparam int                   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LAP_IDX_W-1:0] LAP_FULL = LAP_IDX_W'(LAP_DEPTH);

    // Bit order for all per-button vectors: {clear, lap_time, start_stop}
    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q, sync2_q, stable_q, evt_q;
    logic [CNT_W-1:0] dbc_q [3];

    assign btn_raw = {clear, lap_time, start_stop};

    always_ff @(posedge clk) begin
        if (res) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            evt_q    <= '0;
            for (int i = 0; i < 3; i++) dbc_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                evt_q[i] <= 1'b0;
                if (sync2_q[i] == stable_q[i]) begin
                    dbc_q[i] <= '0;
                end else if (dbc_q[i] == CNT_LAST) begin
                    // level accepted; only a rising acceptance is an event
                    stable_q[i] <= sync2_q[i];
                    evt_q[i]    <= sync2_q[i];
                    dbc_q[i]    <= '0;
                end else begin
                    dbc_q[i] <= dbc_q[i] + CNT_W'(1);
                end
            end
        end
    end

    logic ev_ss, ev_lap, ev_clr;
    assign ev_ss  = evt_q[0];
    assign ev_lap = evt_q[1];
    assign ev_clr = evt_q[2];

    logic [1:0]           state_q, state_d;
    logic                 disp_q, disp_d, ovf_q, ovf_d;
    logic                 cen_q, cclr_q;
    logic [LAP_IDX_W-1:0] lap_cnt_q, lap_cnt_d;
    logic [TIME_W-1:0]    slot_q [LAP_DEPTH];
    logic [TIME_W-1:0]    lap_data_q, rd_d;
    logic                 capture, bank_clr;

    always_comb begin
        state_d   = state_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        lap_cnt_d = lap_cnt_q;
        capture   = 1'b0;
        bank_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ev_ss)       state_d  = ST_RUN;
                else if (ev_clr) bank_clr = 1'b1;
            end
            ST_RUN: begin
                if (ev_lap) begin
                    disp_d = ~disp_q;
                    if (lap_cnt_q == LAP_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        capture   = 1'b1;
                        lap_cnt_d = lap_cnt_q + LAP_IDX_W'(1);
                    end
                end
                if (ev_ss) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (ev_clr) begin
                    state_d  = ST_IDLE;
                    bank_clr = 1'b1;
                    disp_d   = 1'b1;
                end else begin
                    if (ev_lap) disp_d  = 1'b1;
                    if (ev_ss)  state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bank_clr) begin
            lap_cnt_d = '0;
            ovf_d     = 1'b0;
        end
    end

    // Readback uses pre-update contents so a same-cycle capture reads old data
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < LAP_DEPTH; i++) begin
            if (LAP_IDX_W'(i) == lap_sel && lap_sel < lap_cnt_q) rd_d = slot_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ST_IDLE;
            cen_q      <= 1'b0;
            cclr_q     <= 1'b0;
            disp_q     <= 1'b1;
            ovf_q      <= 1'b0;
            lap_cnt_q  <= '0;
            lap_data_q <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) slot_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cen_q      <= (state_d == ST_RUN);
            cclr_q     <= bank_clr;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            lap_cnt_q  <= lap_cnt_d;
            lap_data_q <= rd_d;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                if (bank_clr)                                      slot_q[i] <= '0;
                else if (capture && lap_cnt_q == LAP_IDX_W'(i)) slot_q[i] <= time_in;
            end
        end
    end

    assign counter_enable = cen_q;
    assign counter_clear  = cclr_q;
    assign display_enable = disp_q;
    assign lap_data       = lap_data_q;
    assign lap_count      = lap_cnt_q;
    assign lap_overflow   = ovf_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Bench for stopwatch_ctrl_fsm: directed scenarios with literal expectations plus
// random button traffic, all cross-checked every cycle against a behavioural model.
module tb_stopwatch_ctrl_fsm;

    localparam int DEB   = 16;
    localparam int DEPTH = 4;
    localparam int TW    = 24;
    localparam int IW    = 3;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          start_stop = 1'b0, lap_time = 1'b0, clear = 1'b0;
    logic [TW-1:0] time_in = '0;
    logic [IW-1:0] lap_sel = '0;
    logic          counter_enable, counter_clear, display_enable, lap_overflow;
    logic [TW-1:0] lap_data;
    logic [IW-1:0] lap_count;
    logic [1:0]    state_out;

    stopwatch_ctrl_fsm #(
        .TIME_W(TW), .LAP_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB), .LAP_IDX_W(IW)
    ) dut (
        .clk(clk), .res(res), .start_stop(start_stop), .lap_time(lap_time),
        .clear(clear), .time_in(time_in), .lap_sel(lap_sel),
        .counter_enable(counter_enable), .counter_clear(counter_clear),
        .display_enable(display_enable), .lap_data(lap_data),
        .lap_count(lap_count), .lap_overflow(lap_overflow), .state_out(state_out)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int cclr_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: state 0 idle, 1 running, 2 stopped; laps kept as a queue
    int            m_state = 0;
    bit            m_cen = 0, m_cclr = 0, m_disp = 1, m_ovf = 0;
    int            m_laps[$];
    logic [TW-1:0] m_lapdata = '0;
    bit            dl1[3], dl2[3], stab[3], evn[3];
    int            run[3];

    task automatic model_step();
        bit raw[3];
        bit ev[3];
        raw[0] = start_stop; raw[1] = lap_time; raw[2] = clear;
        if (res) begin
            m_state = 0; m_cen = 0; m_cclr = 0; m_disp = 1; m_ovf = 0;
            m_laps.delete(); m_lapdata = '0;
            for (int b = 0; b < 3; b++) begin
                dl1[b] = 0; dl2[b] = 0; stab[b] = 0; evn[b] = 0; run[b] = 0;
            end
            return;
        end
        for (int b = 0; b < 3; b++) ev[b] = evn[b];
        m_lapdata = (int'(lap_sel) < m_laps.size()) ? TW'(m_laps[lap_sel]) : '0;
        m_cclr = 0;
        case (m_state)
            0: if (ev[0]) m_state = 1;
               else if (ev[2]) begin m_laps.delete(); m_ovf = 0; m_cclr = 1; end
            1: begin
                if (ev[1]) begin
                    if (m_laps.size() < DEPTH) m_laps.push_back(int'(time_in));
                    else m_ovf = 1;
                    m_disp = !m_disp;
                end
                if (ev[0]) m_state = 2;
            end
            default: begin
                if (ev[2]) begin
                    m_state = 0; m_laps.delete(); m_ovf = 0; m_cclr = 1; m_disp = 1;
                end else begin
                    if (ev[1]) m_disp = 1;
                    if (ev[0]) m_state = 1;
                end
            end
        endcase
        m_cen = (m_state == 1);
        // a level is accepted after DEB consecutive samples differing from the stable level
        for (int b = 0; b < 3; b++) begin
            evn[b] = 0;
            if (dl2[b] != stab[b]) begin
                run[b]++;
                if (run[b] == DEB) begin
                    stab[b] = dl2[b];
                    run[b]  = 0;
                    evn[b]  = stab[b];
                end
            end else begin
                run[b] = 0;
            end
            dl2[b] = dl1[b];
            dl1[b] = raw[b];
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (counter_clear) cclr_seen++;
        if (chk_en) begin
            chk("m_state",   32'(state_out),      32'(m_state));
            chk("m_cen",     32'(counter_enable), 32'(m_cen));
            chk("m_cclr",    32'(counter_clear),  32'(m_cclr));
            chk("m_disp",    32'(display_enable), 32'(m_disp));
            chk("m_ovf",     32'(lap_overflow),   32'(m_ovf));
            chk("m_lapcnt",  32'(lap_count),      32'(m_laps.size()));
            chk("m_lapdata", 32'(lap_data),       32'(m_lapdata));
        end
    end

    task automatic press(input bit ss, input bit lp, input bit cl, input int hold);
        @(negedge clk);
        start_stop = ss; lap_time = lp; clear = cl;
        repeat (hold) @(negedge clk);
        start_stop = 0; lap_time = 0; clear = 0;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic read_slot(input int sel, input logic [TW-1:0] exp, input string nm);
        lap_sel = IW'(sel);
        @(negedge clk);
        chk(nm, 32'(lap_data), 32'(exp));
    endtask

    int dur;

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_cen",   32'(counter_enable), 32'd0);
        chk("rst_cclr",  32'(counter_clear), 32'd0);
        chk("rst_disp",  32'(display_enable), 32'd1);
        chk("rst_lapcnt", 32'(lap_count), 32'd0);
        chk("rst_ovf",   32'(lap_overflow), 32'd0);
        chk("rst_lapdata", 32'(lap_data), 32'd0);
        res = 1'b0;

        // short press never reaches the debounce threshold
        start_stop = 1'b1;
        repeat (10) @(negedge clk);
        start_stop = 1'b0;
        repeat (30) @(negedge clk);
        chk("glitch_state", 32'(state_out), 32'd0);

        // event latency: state changes on exactly the DEB+3rd edge after the press
        start_stop = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        chk("lat_before", 32'(state_out), 32'd0);
        @(negedge clk);
        chk("lat_state", 32'(state_out), 32'd1);
        chk("lat_cen",   32'(counter_enable), 32'd1);
        repeat (40 - DEB - 3) @(negedge clk);
        start_stop = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        chk("hold_one_event", 32'(state_out), 32'd1);

        press(1, 0, 0, 25);
        chk("stop_state", 32'(state_out), 32'd2);
        chk("stop_cen",   32'(counter_enable), 32'd0);
        press(1, 0, 0, 25);
        chk("restart_state", 32'(state_out), 32'd1);

        time_in = 24'h000123;
        press(0, 1, 0, 25);
        chk("lap1_cnt",  32'(lap_count), 32'd1);
        chk("lap1_disp", 32'(display_enable), 32'd0);
        read_slot(0, 24'h000123, "lap1_data");
        time_in = 24'h000456;
        press(0, 1, 0, 25);
        chk("lap2_disp", 32'(display_enable), 32'd1);
        read_slot(1, 24'h000456, "lap2_data");
        time_in = 24'h000789; press(0, 1, 0, 25);
        time_in = 24'h000abc; press(0, 1, 0, 25);
        time_in = 24'h000def; press(0, 1, 0, 25);
        chk("ovf_cnt",  32'(lap_count), 32'd4);
        chk("ovf_flag", 32'(lap_overflow), 32'd1);
        chk("ovf_disp", 32'(display_enable), 32'd0);
        read_slot(3, 24'h000abc, "ovf_slot3");
        read_slot(4, 24'h000000, "sel_beyond");

        press(1, 0, 0, 25);
        chk("stop2_state", 32'(state_out), 32'd2);
        cclr_seen = 0;
        press(0, 0, 1, 25);
        chk("clr_pulses", 32'(cclr_seen), 32'd1);
        chk("clr_state",  32'(state_out), 32'd0);
        chk("clr_cnt",    32'(lap_count), 32'd0);
        chk("clr_ovf",    32'(lap_overflow), 32'd0);
        chk("clr_disp",   32'(display_enable), 32'd1);

        press(1, 0, 0, 25);
        time_in = 24'h000321;
        press(1, 1, 0, 25);
        chk("sim_state", 32'(state_out), 32'd2);
        chk("sim_cnt",   32'(lap_count), 32'd1);
        read_slot(0, 24'h000321, "sim_data");
        press(1, 0, 1, 25);
        chk("clrwin_state", 32'(state_out), 32'd0);
        chk("clrwin_cnt",   32'(lap_count), 32'd0);

        // reset in the middle of a start_stop debounce
        press(1, 0, 0, 25);
        time_in = 24'h000777; press(0, 1, 0, 25);
        time_in = 24'h000888; press(0, 1, 0, 25);
        chk("pre_rst_cnt", 32'(lap_count), 32'd2);
        start_stop = 1'b1;
        repeat (8) @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
        start_stop = 1'b0;
        res = 1'b0;
        chk("mid_rst_state", 32'(state_out), 32'd0);
        chk("mid_rst_cen",   32'(counter_enable), 32'd0);
        chk("mid_rst_disp",  32'(display_enable), 32'd1);
        chk("mid_rst_cnt",   32'(lap_count), 32'd0);
        repeat (40) @(negedge clk);
        chk("post_rst_state", 32'(state_out), 32'd0);

        for (int seg = 0; seg < 300; seg++) begin
            dur = int'($urandom_range(1, 40));
            start_stop = ($urandom_range(0, 3) == 0);
            lap_time   = ($urandom_range(0, 2) == 0);
            clear      = ($urandom_range(0, 5) == 0);
            res        = ($urandom_range(0, 60) == 0);
            for (int c = 0; c < dur; c++) begin
                time_in = TW'($urandom);
                lap_sel = IW'($urandom_range(0, 7));
                @(negedge clk);
                res = 1'b0;
            end
        end
        start_stop = 0; lap_time = 0; clear = 0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
